periph_bus_xbar: RTL and testbench
==================================

# periph_bus_xbar

Parametrised request/grant crossbar connecting NB_MASTER word-addressed master ports (core data, debug, SPI-slave DMA) to NB_SLAVE memory-mapped regions through a programmable address map. It adds three things to a fixed 3×3 interconnect: per-slave round-robin arbitration, in-order response routing through per-slave ID FIFOs with multiple outstanding transactions, and decode-error responses for unmapped addresses. It sits between the core region and the memory and peripheral subsystems in the SoC top.

## Interface
- NB_MASTER, 3: number of master ports (1..8)
- NB_SLAVE, 3: number of slave regions (1..8)
- OUTSTANDING, 2: depth of each per-slave ID FIFO (power of two, ≥1)
- START_ADDR, {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000}: packed NB_SLAVE×32 region bases, slave 0 in the LSBs
- END_ADDR, {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF}: packed inclusive region ends
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_req_i  in  NB_MASTER  request per master
- m_addr_i  in  NB_MASTER×32  byte address
- m_we_i  in  NB_MASTER  1 = write
- m_be_i  in  NB_MASTER×4  byte enables
- m_wdata_i  in  NB_MASTER×32  write data
- m_gnt_o  out  NB_MASTER  request accepted this cycle
- m_rvalid_o  out  NB_MASTER  response valid
- m_rdata_o  out  NB_MASTER×32  read data
- m_err_o  out  NB_MASTER  decode error, qualified by m_rvalid_o
- s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  out  NB_SLAVE×(1/32/1/4/32)  forwarded request
- s_gnt_i  in  NB_SLAVE  slave accepted request
- s_rvalid_i  in  NB_SLAVE  slave response, in order, ≥1 cycle after its gnt
- s_rdata_i  in  NB_SLAVE×32  slave read data

## Operation
- Decode: a master targets the lowest-index slave whose START ≤ addr ≤ END. A master hitting no slave targets the internal error slave.
- Each master has a pending flag. A pending master is masked from arbitration, so each master has at most one outstanding transaction.
- Per-slave round-robin: among unmasked requesters for slave s, the first index at or after rr_ptr[s] (wrapping) is forwarded on s_req_o[s] with its addr/we/be/wdata.
  - s_req_o[s] is suppressed while the ID FIFO of slave s is full.
  - On s_req_o[s]&&s_gnt_i[s]: m_gnt_o of the winner = 1, its master ID is pushed, its pending flag is set, and rr_ptr[s] = winner+1 mod NB_MASTER.
  - With no grant, rr_ptr is held.
- Response: on s_rvalid_i[s], pop the FIFO head ID h. Drive m_rvalid_o[h]=1, m_rdata_o[h]=s_rdata_i[s], m_err_o[h]=0, and clear pending[h].
  - s_rvalid_i with an empty FIFO is ignored.
  - Push and pop in the same cycle are both performed, so occupancy is unchanged.
- Error slave: always grants (subject to pending) with fixed-priority lowest index. The next cycle it returns rvalid=1, err=1, rdata=0.
- A master's pending flag may be cleared and a new grant given to it in the same cycle its response returns.
- Idle outputs: m_rdata_o=0, s_addr_o/s_wdata_o/s_be_o/s_we_o=0 when the corresponding valid/req is low.

## Timing
- Request path is combinational: m_req_i → s_req_o, and s_gnt_i → m_gnt_o, in the same cycle.
- Response path is combinational: s_rvalid_i → m_rvalid_o with 0 added latency. Error responses arrive exactly 1 cycle after gnt.
- Reset values: all outputs 0, rr_ptr=0, FIFOs empty, pending=0.
- Reset mid-transaction: in-flight IDs are discarded, and late slave rvalids after reset are ignored via the empty-FIFO rule.
- Full FIFO: no new grant to that slave until a pop. A pop and a push may occur in the same cycle the FIFO is full.

## Structure
- Package periph_bus_pkg holds ADDR_W=32, DATA_W=32, BE_W=4, the master-ID width function (clog2, min 1), and the bus request struct (addr, we, be, wdata).
- Sub-module bus_id_fifo (parametrised depth and width, push/pop/full/empty), instantiated once per slave.
- Round-robin arbitration and decode stay inline in generate loops.

## Test plan
- Single master 0 reads 0x0010_0004 from slave 1; slave gnt same cycle, rvalid 2 cycles later with 0xDEADBEEF → m_rvalid_o[0]=1, m_rdata_o[0]=0xDEADBEEF, err=0, pending cleared.
- Masters 0,1,2 request slave 0 continuously with s_gnt_i=1 and 1-cycle rvalid → grants rotate 0,1,2,0; each master is re-granted only after its response.
- OUTSTANDING=2, slave 2 holds rvalid low: masters 0 and 1 are granted, master 2 gets no s_req_o; first rvalid pops ID 0 and grants master 2 in the same cycle.
- Master 1 accesses 0x2000_0000 (unmapped) → gnt same cycle; next cycle rvalid=1, err=1, rdata=0; no s_req_o asserted.
- Overlapping map (slave 0 and slave 1 both cover 0x100) → access goes to slave 0 only.
- Assert rst with two responses outstanding, then drive s_rvalid_i after reset → all m_rvalid_o stay 0 and no pending flag is set.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared widths, the master-ID width helper and the bus request bundle
// used by the peripheral crossbar.
package periph_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_id_fifo.sv
// Small in-order ID FIFO remembering which master owns each outstanding
// slave transaction.
module bus_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/periph_bus_xbar.sv
// Request/grant crossbar: address decode, per-slave round-robin with
// ID FIFOs for in-order response routing, and an internal decode-error slave.
module periph_bus_xbar
    import periph_bus_pkg::*;
#(
    parameter int NB_MASTER   = 3,
    parameter int NB_SLAVE    = 3,
    parameter int OUTSTANDING = 2,
    parameter logic [NB_SLAVE*ADDR_W-1:0] START_ADDR = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
    parameter logic [NB_SLAVE*ADDR_W-1:0] END_ADDR   = {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NB_MASTER-1:0]          m_req_i,
    input  logic [NB_MASTER*ADDR_W-1:0]   m_addr_i,
    input  logic [NB_MASTER-1:0]          m_we_i,
    input  logic [NB_MASTER*BE_W-1:0]     m_be_i,
    input  logic [NB_MASTER*DATA_W-1:0]   m_wdata_i,
    output logic [NB_MASTER-1:0]          m_gnt_o,
    output logic [NB_MASTER-1:0]          m_rvalid_o,
    output logic [NB_MASTER*DATA_W-1:0]   m_rdata_o,
    output logic [NB_MASTER-1:0]          m_err_o,
    output logic [NB_SLAVE-1:0]           s_req_o,
    output logic [NB_SLAVE*ADDR_W-1:0]    s_addr_o,
    output logic [NB_SLAVE-1:0]           s_we_o,
    output logic [NB_SLAVE*BE_W-1:0]      s_be_o,
    output logic [NB_SLAVE*DATA_W-1:0]    s_wdata_o,
    input  logic [NB_SLAVE-1:0]           s_gnt_i,
    input  logic [NB_SLAVE-1:0]           s_rvalid_i,
    input  logic [NB_SLAVE*DATA_W-1:0]    s_rdata_i
);
    localparam int ID_W  = id_width(NB_MASTER);
    localparam int TGT_W = id_width(NB_SLAVE + 1);

    bus_req_t                    m_bus [NB_MASTER];
    logic [NB_MASTER*TGT_W-1:0]  tgt_flat;
    logic [NB_MASTER-1:0]        eligible;
    logic [NB_MASTER-1:0]        pending_q, pending_d;
    logic [NB_SLAVE*ID_W-1:0]    winner_flat, head_flat;
    logic [NB_SLAVE-1:0]         s_fire, fifo_empty;
    logic                        err_fire, err_valid_q;
    logic [ID_W-1:0]             err_id_d, err_id_q;

    genvar gi;

    for (gi = 0; gi < NB_MASTER; gi++) begin : g_master
        logic [TGT_W-1:0] tgt;

        // Walk downwards so the lowest-index matching region wins overlaps.
        always_comb begin
            tgt = TGT_W'(NB_SLAVE);
            for (int s = NB_SLAVE - 1; s >= 0; s--) begin
                if (m_addr_i[gi*ADDR_W +: ADDR_W] >= START_ADDR[s*ADDR_W +: ADDR_W] &&
                    m_addr_i[gi*ADDR_W +: ADDR_W] <= END_ADDR[s*ADDR_W +: ADDR_W]) begin
                    tgt = TGT_W'(s);
                end
            end
        end

        assign tgt_flat[gi*TGT_W +: TGT_W] = tgt;
        assign m_bus[gi] = '{addr:  m_addr_i[gi*ADDR_W +: ADDR_W],
                             we:    m_we_i[gi],
                             be:    m_be_i[gi*BE_W +: BE_W],
                             wdata: m_wdata_i[gi*DATA_W +: DATA_W]};
        // A response arriving this cycle frees the master for a fresh grant.
        assign eligible[gi] = m_req_i[gi] && !(pending_q[gi] && !m_rvalid_o[gi]);
    end

    for (gi = 0; gi < NB_SLAVE; gi++) begin : g_slave
        logic [NB_MASTER-1:0] cand;
        logic [ID_W-1:0]      win, head, rr_ptr_q, rr_ptr_d;
        logic                 found, full, empty, fire;

        always_comb begin
            cand  = '0;
            win   = '0;
            found = 1'b0;
            for (int m = 0; m < NB_MASTER; m++) begin
                cand[m] = eligible[m] && (tgt_flat[m*TGT_W +: TGT_W] == TGT_W'(gi));
            end
            for (int i = 0; i < NB_MASTER; i++) begin
                if (!found && cand[(int'(rr_ptr_q) + i) % NB_MASTER]) begin
                    found = 1'b1;
                    win   = ID_W'((int'(rr_ptr_q) + i) % NB_MASTER);
                end
            end
        end

        assign s_req_o[gi] = found && !rst && (!full || s_rvalid_i[gi]);
        assign fire        = s_req_o[gi] && s_gnt_i[gi];
        assign rr_ptr_d    = !fire ? rr_ptr_q :
                             (int'(win) == NB_MASTER - 1) ? '0 : win + 1'b1;

        assign s_addr_o[gi*ADDR_W +: ADDR_W]  = s_req_o[gi] ? m_bus[win].addr  : '0;
        assign s_we_o[gi]                     = s_req_o[gi] ? m_bus[win].we    : 1'b0;
        assign s_be_o[gi*BE_W +: BE_W]        = s_req_o[gi] ? m_bus[win].be    : '0;
        assign s_wdata_o[gi*DATA_W +: DATA_W] = s_req_o[gi] ? m_bus[win].wdata : '0;

        assign s_fire[gi]                  = fire;
        assign fifo_empty[gi]              = empty;
        assign winner_flat[gi*ID_W +: ID_W] = win;
        assign head_flat[gi*ID_W +: ID_W]   = head;

        always_ff @(posedge clk) begin
            if (rst) rr_ptr_q <= '0;
            else     rr_ptr_q <= rr_ptr_d;
        end

        bus_id_fifo #(
            .DEPTH (OUTSTANDING),
            .WIDTH (ID_W)
        ) u_id_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (fire),
            .data_i  (win),
            .pop_i   (s_rvalid_i[gi]),
            .data_o  (head),
            .full_o  (full),
            .empty_o (empty)
        );
    end

    // Error slave: fixed priority, lowest index first, answers one cycle later.
    always_comb begin
        err_fire = 1'b0;
        err_id_d = '0;
        for (int m = NB_MASTER - 1; m >= 0; m--) begin
            if (eligible[m] && tgt_flat[m*TGT_W +: TGT_W] == TGT_W'(NB_SLAVE)) begin
                err_fire = !rst;
                err_id_d = ID_W'(m);
            end
        end
    end

    always_comb begin
        m_gnt_o = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (s_fire[s]) m_gnt_o[winner_flat[s*ID_W +: ID_W]] = 1'b1;
        end
        if (err_fire) m_gnt_o[err_id_d] = 1'b1;
    end

    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (!rst && s_rvalid_i[s] && !fifo_empty[s]) begin
                m_rvalid_o[head_flat[s*ID_W +: ID_W]] = 1'b1;
                m_rdata_o[int'(head_flat[s*ID_W +: ID_W])*DATA_W +: DATA_W] = s_rdata_i[s*DATA_W +: DATA_W];
            end
        end
        if (!rst && err_valid_q) begin
            m_rvalid_o[err_id_q] = 1'b1;
            m_err_o[err_id_q]    = 1'b1;
        end
    end

    assign pending_d = (pending_q & ~m_rvalid_o) | m_gnt_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            err_valid_q <= 1'b0;
            err_id_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            err_valid_q <= err_fire;
            err_id_q    <= err_id_d;
        end
    end

endmodule

// File: tb/tb_periph_bus_xbar.sv
// Directed bench for periph_bus_xbar: expected responses go into a
// scoreboard queue and a negedge monitor pops them as m_rvalid_o fires.
module tb_periph_bus_xbar;

    logic        clk;
    logic        rst;
    logic [2:0]  m_req_i, m_we_i, m_gnt_o, m_rvalid_o, m_err_o;
    logic [95:0] m_addr_i, m_wdata_i, m_rdata_o;
    logic [11:0] m_be_i, s_be_o;
    logic [2:0]  s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
    logic [95:0] s_addr_o, s_wdata_o, s_rdata_i;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Slave 0 and slave 1 overlap on the low 4 KiB; slave 0 must win there.
    periph_bus_xbar #(
        .NB_MASTER   (3),
        .NB_SLAVE    (3),
        .OUTSTANDING (2),
        .START_ADDR  ({32'h1A10_0000, 32'h0000_0000, 32'h0000_0000}),
        .END_ADDR    ({32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h0000_0FFF})
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req_i    (m_req_i),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_gnt_i    (s_gnt_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (m_rvalid_o[m] === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected m%0d got data=%h err=%b required none",
                             m, m_rdata_o[m*32 +: 32], m_err_o[m]);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.m != m || m_rdata_o[m*32 +: 32] !== e.data || m_err_o[m] !== e.err) begin
                        errors++;
                        $display("FAIL rsp m%0d got data=%h err=%b required m%0d data=%h err=%b",
                                 m, m_rdata_o[m*32 +: 32], m_err_o[m], e.m, e.data, e.err);
                    end else begin
                        $display("rsp m%0d data=%h err=%b ok", m, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_m(input int m, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata);
        m_req_i[m]           = 1'b1;
        m_addr_i[m*32 +: 32] = addr;
        m_we_i[m]            = we;
        m_be_i[m*4 +: 4]     = 4'hF;
        m_wdata_i[m*32 +: 32] = wdata;
    endtask

    task automatic clear_all();
        m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
        s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;
    endtask

    task automatic rsp(input int s, input logic [31:0] data);
        s_rvalid_i[s]         = 1'b1;
        s_rdata_i[s*32 +: 32] = data;
    endtask

    initial begin
        clear_all();
        rst = 1'b1;
        tick();
        // Requests during reset must not leak through.
        drive_m(1, 32'h2000_0000, 1'b0, 32'h0);
        drive_m(0, 32'h0010_0000, 1'b0, 32'h0);
        s_gnt_i = 3'b111;
        #1;
        chk("rst_gnt", {29'd0, m_gnt_o}, 32'd0);
        chk("rst_sreq", {29'd0, s_req_o}, 32'd0);
        tick();
        clear_all();
        rst = 1'b0;
        #1;
        chk("idle_rvalid", {29'd0, m_rvalid_o}, 32'd0);
        chk("idle_saddr1", s_addr_o[63:32], 32'd0);

        // Single read from slave 1, response two cycles after grant.
        tick();
        drive_m(0, 32'h0010_0004, 1'b0, 32'h0);
        s_gnt_i = 3'b010;
        #1;
        chk("t1_sreq", {29'd0, s_req_o}, 32'h2);
        chk("t1_gnt", {29'd0, m_gnt_o}, 32'h1);
        chk("t1_addr1", s_addr_o[63:32], 32'h0010_0004);
        chk("t1_addr0_idle", s_addr_o[31:0], 32'h0);
        tick();
        s_gnt_i = 3'b000;
        #1;
        chk("t1_pending_mask", {29'd0, s_req_o}, 32'h0);
        tick();
        rsp(1, 32'hDEAD_BEEF);
        sb_q.push_back('{m: 0, data: 32'hDEAD_BEEF, err: 1'b0});
        #1;
        chk("t1_clear_same_cycle", {29'd0, s_req_o}, 32'h2);
        tick();
        clear_all();

        // Unmapped write from master 1; re-request on the response cycle.
        tick();
        drive_m(1, 32'h2000_0000, 1'b1, 32'h0000_1234);
        #1;
        chk("err_gnt", {29'd0, m_gnt_o}, 32'h2);
        chk("err_no_sreq", {29'd0, s_req_o}, 32'h0);
        tick();
        sb_q.push_back('{m: 1, data: 32'h0, err: 1'b1});
        #1;
        chk("err_regnt", {29'd0, m_gnt_o}, 32'h2);
        tick();
        clear_all();
        sb_q.push_back('{m: 1, data: 32'h0, err: 1'b1});
        tick();

        // Round robin on slave 0 with 1-cycle responses.
        tick();
        drive_m(0, 32'h0000_0010, 1'b0, 32'h0);
        drive_m(1, 32'h0000_0020, 1'b0, 32'h0);
        drive_m(2, 32'h0000_0030, 1'b0, 32'h0);
        s_gnt_i = 3'b001;
        #1;
        chk("rr_gnt0", {29'd0, m_gnt_o}, 32'h1);
        chk("rr_addr0", s_addr_o[31:0], 32'h0000_0010);
        tick();
        rsp(0, 32'h0000_00A0);
        sb_q.push_back('{m: 0, data: 32'h0000_00A0, err: 1'b0});
        #1;
        chk("rr_gnt1", {29'd0, m_gnt_o}, 32'h2);
        chk("rr_addr1", s_addr_o[31:0], 32'h0000_0020);
        tick();
        rsp(0, 32'h0000_00A1);
        sb_q.push_back('{m: 1, data: 32'h0000_00A1, err: 1'b0});
        #1;
        chk("rr_gnt2", {29'd0, m_gnt_o}, 32'h4);
        tick();
        rsp(0, 32'h0000_00A2);
        sb_q.push_back('{m: 2, data: 32'h0000_00A2, err: 1'b0});
        #1;
        chk("rr_gnt0_again", {29'd0, m_gnt_o}, 32'h1);
        tick();
        clear_all();
        rsp(0, 32'h0000_00A3);
        sb_q.push_back('{m: 0, data: 32'h0000_00A3, err: 1'b0});
        tick();
        clear_all();

        // Slave 2 FIFO fills at two outstanding transactions.
        tick();
        drive_m(0, 32'h1A10_0000, 1'b0, 32'h0);
        drive_m(1, 32'h1A10_0004, 1'b0, 32'h0);
        drive_m(2, 32'h1A10_0008, 1'b0, 32'h0);
        s_gnt_i = 3'b100;
        #1;
        chk("full_gnt0", {29'd0, m_gnt_o}, 32'h1);
        tick();
        #1;
        chk("full_gnt1", {29'd0, m_gnt_o}, 32'h2);
        tick();
        #1;
        chk("full_no_sreq", {29'd0, s_req_o}, 32'h0);
        chk("full_no_gnt", {29'd0, m_gnt_o}, 32'h0);
        tick();
        rsp(2, 32'h0000_00B0);
        sb_q.push_back('{m: 0, data: 32'h0000_00B0, err: 1'b0});
        #1;
        chk("full_pop_gnt2", {29'd0, m_gnt_o}, 32'h4);
        chk("full_pop_addr2", s_addr_o[95:64], 32'h1A10_0008);

        // Reset with masters 1 and 2 still outstanding; late rvalid ignored.
        tick();
        clear_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rsp(2, 32'h0000_00C0);
        #1;
        chk("late_rvalid", {29'd0, m_rvalid_o}, 32'h0);
        tick();
        clear_all();
        drive_m(1, 32'h0020_0000, 1'b1, 32'hCAFE_0001);
        #1;
        chk("post_rst_sreq", {29'd0, s_req_o}, 32'h2);
        chk("post_rst_we", {29'd0, s_we_o}, 32'h2);
        chk("post_rst_wdata", s_wdata_o[63:32], 32'hCAFE_0001);
        chk("post_rst_be", {20'd0, s_be_o}, 32'h0F0);
        tick();
        clear_all();

        // Overlapping regions: lowest slave index wins.
        tick();
        drive_m(2, 32'h0000_0100, 1'b0, 32'h0);
        s_gnt_i = 3'b011;
        #1;
        chk("ovl_sreq", {29'd0, s_req_o}, 32'h1);
        chk("ovl_gnt", {29'd0, m_gnt_o}, 32'h4);
        tick();
        clear_all();
        rsp(0, 32'h0000_00D0);
        sb_q.push_back('{m: 2, data: 32'h0000_00D0, err: 1'b0});
        tick();
        clear_all();
        tick();
        tick();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
